// File: rtl/bot_request_responder_pkg.sv
// Shared widths, constants and request classification for the bottom
// request responder and its FIFO.
package bot_request_responder_pkg;

    localparam int unsigned BOT_WIDTH        = 128;
    localparam int unsigned MISS_COUNT_WIDTH = 16;

    // Bubble beat: no valid bottom, payload forced to zero.
    localparam logic                        BUBBLE_START   = 1'b0;
    localparam logic [BOT_WIDTH-1:0]        BUBBLE_BOT     = '0;
    localparam logic [MISS_COUNT_WIDTH-1:0] MISS_COUNT_MAX = '1;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_POP,
        REQ_MISS
    } req_kind_e;

endpackage

// File: rtl/bot_request_responder_bot_fifo.sv
// Register-based synchronous FIFO holding bottom vectors, with a
// registered occupancy count and a synchronous clear.
module bot_fifo
    import bot_request_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [BOT_WIDTH-1:0]  wdata,
    output logic [BOT_WIDTH-1:0]  rdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [BOT_WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,  count_d;
    logic                  do_push, do_pop;

    // Occupancy never exceeds DEPTH, so its MSB alone flags full.
    always_comb begin
        full    = count_q[DEPTH_LOG2];
        empty   = (count_q == '0);
        count   = count_q;
        rdata   = mem_q[rd_ptr_q];
        do_push = push && !full && !clear;
        do_pop  = pop && !empty && !clear;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/bot_request_responder.sv
// Answers each graph request with one {start, bottom, index} beat a fixed
// number of cycles later, serving bottoms from a FIFO or a bubble on miss.
module bot_request_responder
    import bot_request_responder_pkg::*;
#(
    parameter int unsigned EXTRA_DATA_WIDTH = 14,
    parameter int unsigned REQUEST_LATENCY  = 3,
    parameter int unsigned FIFO_DEPTH_LOG2  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        botValid,
    input  logic [BOT_WIDTH-1:0]        botData,
    output logic                        botReady,
    input  logic                        requestGraph,
    output logic [BOT_WIDTH-1:0]        botOut,
    output logic                        start,
    output logic [EXTRA_DATA_WIDTH-1:0] extraDataOut,
    output logic [MISS_COUNT_WIDTH-1:0] missCount,
    output logic [FIFO_DEPTH_LOG2:0]    fillLevel
);

    logic [BOT_WIDTH-1:0]        head;
    logic                        fifo_full, fifo_empty;
    logic                        push;
    req_kind_e                   req_kind;
    logic                        in_start;
    logic [BOT_WIDTH-1:0]        in_bot;
    logic [EXTRA_DATA_WIDTH-1:0] in_tag;
    logic [EXTRA_DATA_WIDTH-1:0] idx_q, idx_d;
    logic [MISS_COUNT_WIDTH-1:0] miss_q, miss_d;

    always_comb begin
        botReady = !fifo_full;
        push     = botValid && !fifo_full;
        req_kind = REQ_IDLE;
        if (requestGraph) req_kind = fifo_empty ? REQ_MISS : REQ_POP;
    end

    bot_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .pop   (req_kind == REQ_POP),
        .wdata (botData),
        .rdata (head),
        .count (fillLevel),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        in_start = BUBBLE_START;
        in_bot   = BUBBLE_BOT;
        in_tag   = '0;
        idx_d    = idx_q;
        miss_d   = miss_q;
        if (clear) begin
            idx_d  = '0;
            miss_d = '0;
        end else if (req_kind == REQ_POP) begin
            in_start = 1'b1;
            in_bot   = head;
            in_tag   = idx_q;
            idx_d    = idx_q + 1'b1;
        end else if (req_kind == REQ_MISS && miss_q != MISS_COUNT_MAX) begin
            miss_d = miss_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= '0;
            miss_q <= '0;
        end else begin
            idx_q  <= idx_d;
            miss_q <= miss_d;
        end
    end

    // Stage 0 captures the answer on the request edge; the last stage drives the outputs.
    for (genvar g = 0; g < REQUEST_LATENCY; g++) begin : g_stage
        logic                        s_in, start_q;
        logic [BOT_WIDTH-1:0]        b_in, bot_q;
        logic [EXTRA_DATA_WIDTH-1:0] t_in, tag_q;

        if (g == 0) begin : g_head
            always_comb begin
                s_in = in_start;
                b_in = in_bot;
                t_in = in_tag;
            end
        end else begin : g_tail
            always_comb begin
                s_in = g_stage[g-1].start_q;
                b_in = g_stage[g-1].bot_q;
                t_in = g_stage[g-1].tag_q;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                start_q <= BUBBLE_START;
                bot_q   <= BUBBLE_BOT;
                tag_q   <= '0;
            end else if (clear) begin
                start_q <= BUBBLE_START;
                bot_q   <= BUBBLE_BOT;
                tag_q   <= '0;
            end else begin
                start_q <= s_in;
                bot_q   <= b_in;
                tag_q   <= t_in;
            end
        end
    end

    always_comb begin
        start        = g_stage[REQUEST_LATENCY-1].start_q;
        botOut       = g_stage[REQUEST_LATENCY-1].bot_q;
        extraDataOut = g_stage[REQUEST_LATENCY-1].tag_q;
        missCount    = miss_q;
    end

endmodule

// File: tb/tb_bot_request_responder.sv
// Bench for bot_request_responder: a directed vector table, corner sequences
// and random traffic against a queue-based model of request/answer behaviour.
module tb_bot_request_responder;
    import bot_request_responder_pkg::*;

    localparam int unsigned L  = 3;
    localparam int unsigned EW = 14;
    localparam int unsigned DL = 4;
    localparam int unsigned DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clear = 1'b0;
    logic              botValid = 1'b0;
    logic [127:0]      botData = '0;
    logic              requestGraph = 1'b0;
    logic              botReady, start;
    logic [127:0]      botOut;
    logic [EW-1:0]     extraDataOut;
    logic [15:0]       missCount;
    logic [DL:0]       fillLevel;
    logic              botReady2, start2;
    logic [127:0]      botOut2;
    logic [1:0]        extraDataOut2;
    logic [15:0]       missCount2;
    logic [DL:0]       fillLevel2;

    always #5 clk = ~clk;

    bot_request_responder #(
        .EXTRA_DATA_WIDTH (EW),
        .REQUEST_LATENCY  (L),
        .FIFO_DEPTH_LOG2  (DL)
    ) dut (
        .clk (clk), .rst (rst), .clear (clear), .botValid (botValid),
        .botData (botData), .botReady (botReady), .requestGraph (requestGraph),
        .botOut (botOut), .start (start), .extraDataOut (extraDataOut),
        .missCount (missCount), .fillLevel (fillLevel)
    );

    // Narrow-tag twin sharing the same stimulus, for index wrap-around.
    bot_request_responder #(
        .EXTRA_DATA_WIDTH (2),
        .REQUEST_LATENCY  (L),
        .FIFO_DEPTH_LOG2  (DL)
    ) dut2 (
        .clk (clk), .rst (rst), .clear (clear), .botValid (botValid),
        .botData (botData), .botReady (botReady2), .requestGraph (requestGraph),
        .botOut (botOut2), .start (start2), .extraDataOut (extraDataOut2),
        .missCount (missCount2), .fillLevel (fillLevel2)
    );

    typedef struct {
        bit           st;
        bit [127:0]   bot;
        int unsigned  tag;
    } beat_t;

    typedef struct {
        bit           c;
        bit           v;
        bit [127:0]   d;
        bit           r;
        bit           es;
        bit [127:0]   eb;
        int unsigned  et;
        int unsigned  ef;
        int unsigned  em;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    bit [127:0]  q[$];
    int unsigned idx = 0;
    int unsigned miss = 0;
    beat_t       resp[int];
    int          edge_n = 0;
    int          cutoff = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic beat_t expected_beat();
        beat_t e;
        int src;
        e.st = 1'b0; e.bot = '0; e.tag = 0;
        src = edge_n - int'(L) + 1;
        if (src > cutoff && resp.exists(src)) e = resp[src];
        return e;
    endfunction

    task automatic model_edge(input bit c, input bit v, input bit [127:0] d, input bit r);
        beat_t b;
        bit rdy;
        b.st = 1'b0; b.bot = '0; b.tag = 0;
        edge_n++;
        if (c) begin
            q.delete();
            idx = 0;
            miss = 0;
            cutoff = edge_n;
        end else begin
            rdy = (q.size() != DEPTH);
            if (r && q.size() > 0) begin
                b.st  = 1'b1;
                b.bot = q.pop_front();
                b.tag = idx;
                idx   = (idx + 1) % (1 << EW);
            end else if (r) begin
                if (miss < 65535) miss++;
            end
            if (v && rdy) q.push_back(d);
        end
        resp[edge_n] = b;
        if (resp.exists(edge_n - 8)) resp.delete(edge_n - 8);
    endtask

    task automatic step(input bit c, input bit v, input bit [127:0] d, input bit r);
        beat_t e;
        @(negedge clk);
        clear = c; botValid = v; botData = d; requestGraph = r;
        @(posedge clk);
        model_edge(c, v, d, r);
        #1;
        e = expected_beat();
        check("start",     128'(start),        128'(e.st));
        check("botOut",    botOut,             e.bot);
        check("tag",       128'(extraDataOut), 128'(e.tag));
        check("tag2",      128'(extraDataOut2),128'(e.tag % 4));
        check("start2",    128'(start2),       128'(e.st));
        check("missCount", 128'(missCount),    128'(miss));
        check("fillLevel", 128'(fillLevel),    128'(q.size()));
        check("botReady",  128'(botReady),     128'(q.size() != DEPTH));
    endtask

    task automatic check_all_zero(input string tagname);
        check({tagname, "_start"},  128'(start),        '0);
        check({tagname, "_botOut"}, botOut,             '0);
        check({tagname, "_tag"},    128'(extraDataOut), '0);
        check({tagname, "_miss"},   128'(missCount),    '0);
        check({tagname, "_fill"},   128'(fillLevel),    '0);
        check({tagname, "_ready"},  128'(botReady),     128'(1));
    endtask

    task automatic async_reset();
        @(negedge clk);
        clear = 1'b0; botValid = 1'b0; requestGraph = 1'b0;
        #2 rst = 1'b0;
        #1 check_all_zero("rst_async");
        @(posedge clk);
        #1 check_all_zero("rst_held");
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        idx = 0;
        miss = 0;
        cutoff = edge_n;
    endtask

    localparam bit [127:0] BA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam bit [127:0] BB = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
    localparam bit [127:0] BC = 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004;
    localparam bit [127:0] BD = 128'hDDDD_0001_DDDD_0002_DDDD_0003_DDDD_0004;

    function automatic bit [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    vec_t tbl[14];

    initial begin
        //            c  v  d   r  es eb  et ef em
        tbl[0]  = '{0, 1, BA, 0, 0, '0, 0, 1, 0};
        tbl[1]  = '{0, 1, BB, 0, 0, '0, 0, 2, 0};
        tbl[2]  = '{0, 1, BC, 0, 0, '0, 0, 3, 0};
        tbl[3]  = '{0, 0, '0, 1, 0, '0, 0, 2, 0};
        tbl[4]  = '{0, 0, '0, 1, 0, '0, 0, 1, 0};
        tbl[5]  = '{0, 0, '0, 1, 1, BA, 0, 0, 0};
        tbl[6]  = '{0, 0, '0, 0, 1, BB, 1, 0, 0};
        tbl[7]  = '{0, 0, '0, 0, 1, BC, 2, 0, 0};
        tbl[8]  = '{0, 0, '0, 0, 0, '0, 0, 0, 0};
        tbl[9]  = '{0, 0, '0, 1, 0, '0, 0, 0, 1};
        tbl[10] = '{0, 1, BD, 0, 0, '0, 0, 1, 1};
        tbl[11] = '{0, 0, '0, 1, 0, '0, 0, 0, 1};
        tbl[12] = '{0, 0, '0, 0, 0, '0, 0, 0, 1};
        tbl[13] = '{0, 0, '0, 0, 1, BD, 3, 0, 1};

        #12 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].r);
            check("tbl_start", 128'(start),        128'(tbl[i].es));
            check("tbl_bot",   botOut,             tbl[i].eb);
            check("tbl_tag",   128'(extraDataOut), 128'(tbl[i].et));
            check("tbl_fill",  128'(fillLevel),    128'(tbl[i].ef));
            check("tbl_miss",  128'(missCount),    128'(tbl[i].em));
        end

        // Fill to capacity, then push into a full FIFO while popping.
        for (int i = 0; i < 16; i++) step(0, 1, rnd128(), 0);
        check("full_ready", 128'(botReady),  '0);
        check("full_fill",  128'(fillLevel), 128'(16));
        step(0, 1, rnd128(), 1);
        check("fullpop_fill",  128'(fillLevel), 128'(15));
        check("fullpop_ready", 128'(botReady),  128'(1));
        for (int i = 0; i < 15 + L; i++) step(0, 0, '0, i < 15);

        // Clear with two beats in flight.
        step(0, 1, rnd128(), 0);
        step(0, 1, rnd128(), 1);
        step(0, 0, '0, 1);
        step(1, 0, '0, 0);
        check("clr_fill", 128'(fillLevel), '0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, '0, 0);
            check("clr_nostart", 128'(start), '0);
        end
        step(0, 1, BA, 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        check("clr_next_start", 128'(start),        128'(1));
        check("clr_next_tag",   128'(extraDataOut), '0);
        check("clr_next_bot",   botOut,             BA);

        // Five more beats: narrow tags run 1,2,3,0,1.
        for (int i = 0; i < 5; i++) step(0, 1, rnd128(), 0);
        for (int i = 0; i < 5 + L; i++) step(0, 0, '0, i < 5);

        // Asynchronous reset with two beats in flight.
        for (int i = 0; i < 3; i++) step(0, 1, rnd128(), 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        async_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, '0, 0);
            check("rst_nostart", 128'(start),    '0);
            check("rst_ready",   128'(botReady), 128'(1));
        end

        // Random traffic with phases biased toward filling and draining.
        for (int i = 0; i < 2000; i++) begin
            int unsigned pv;
            int unsigned pr;
            pv = ((i / 200) % 2 == 0) ? 75 : 35;
            pr = ((i / 200) % 2 == 0) ? 35 : 75;
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 99) < pv,
                 rnd128(),
                 $urandom_range(0, 99) < pr);
        end

        // Miss counter saturation.
        step(1, 0, '0, 0);
        for (int i = 0; i < 65540; i++) step(0, 0, '0, 1);
        check("miss_sat", 128'(missCount), 128'(16'hFFFF));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
